// File: rtl/bench_result_uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bench_result_uart_pkg : ASCII/report constants and FSM encoding           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package bench_result_uart_pkg;

    localparam logic [7:0] ASCII_C     = 8'h43;
    localparam logic [7:0] ASCII_EQ    = 8'h3D;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_A_OFS = 8'h37;

    localparam int CHARS_PER_LINE = 13;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SHIFT  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] v);
        return (v < 4'd10) ? (ASCII_0 + {4'd0, v}) : (ASCII_A_OFS + {4'd0, v});
    endfunction

endpackage
`default_nettype wire

// File: rtl/bench_result_uart_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bench_result_uart_if : start/count inputs and UART/status outputs        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface bench_result_uart_if;
    logic        start;
    logic [31:0] t_cond0;
    logic [31:0] t_cond1;
    logic [31:0] t_cond2;
    logic [31:0] t_cond3;
    logic        uart_tx;
    logic        busy;
    logic        done;

    modport master (
        output start, t_cond0, t_cond1, t_cond2, t_cond3,
        input  uart_tx, busy, done
    );

    modport slave (
        input  start, t_cond0, t_cond1, t_cond2, t_cond3,
        output uart_tx, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/bench_result_uart_tx_byte.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_byte : 8N1 serialiser for one byte, pulses tx_done after stop    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 1085
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       uart_tx
);
    localparam int                   TIMER_W  = $clog2(CLKS_PER_BIT);
    localparam logic [TIMER_W-1:0]   BIT_LAST = TIMER_W'(CLKS_PER_BIT - 1);

    logic               active_q;
    logic [3:0]         bit_cnt_q;
    logic [TIMER_W-1:0] timer_q;
    logic [7:0]         shift_q;
    logic               tx_q;
    logic               done_q;

    // bit_cnt_q: 0 = start bit, 1..8 = data bits, 9 = stop bit
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            active_q  <= 1'b0;
            bit_cnt_q <= 4'd0;
            timer_q   <= '0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!active_q) begin
                if (tx_valid) begin
                    active_q  <= 1'b1;
                    shift_q   <= tx_data;
                    tx_q      <= 1'b0;
                    bit_cnt_q <= 4'd0;
                    timer_q   <= '0;
                end
            end else if (timer_q != BIT_LAST) begin
                timer_q <= timer_q + 1'b1;
            end else begin
                timer_q <= '0;
                if (bit_cnt_q == 4'd9) begin
                    active_q  <= 1'b0;
                    bit_cnt_q <= 4'd0;
                    done_q    <= 1'b1;
                end else begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 4'd8) begin
                        tx_q <= 1'b1;
                    end else begin
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                    end
                end
            end
        end
    end

    assign tx_ready = !active_q;
    assign tx_done  = done_q;
    assign uart_tx  = tx_q;

endmodule
`default_nettype wire

// File: rtl/bench_result_uart.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bench_result_uart : snapshots cycle counts, streams "C<n>=HEX\r\n" lines |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module bench_result_uart
    import bench_result_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1085,
    parameter int N_COND       = 4
) (
    input  logic                sysclk,
    input  logic                rst,
    bench_result_uart_if.slave  bus
);
    localparam logic [3:0] LAST_CHAR = 4'(CHARS_PER_LINE - 1);
    localparam logic [1:0] LAST_COND = 2'(N_COND - 1);

    state_t      state_q, state_d;
    logic [3:0]  char_idx_q, char_idx_d;
    logic [1:0]  cond_idx_q, cond_idx_d;
    logic [31:0] snap_q [4];
    logic        snap_en;
    logic        tx_valid, tx_ready, tx_done;
    logic [7:0]  tx_data;
    logic [31:0] cur_word;
    logic [3:0]  nib_k;
    logic [3:0]  cur_nib;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            char_idx_q <= 4'd0;
            cond_idx_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            char_idx_q <= char_idx_d;
            cond_idx_q <= cond_idx_d;
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) snap_q[i] <= 32'd0;
        end else if (snap_en) begin
            snap_q[0] <= bus.t_cond0;
            snap_q[1] <= bus.t_cond1;
            snap_q[2] <= bus.t_cond2;
            snap_q[3] <= bus.t_cond3;
        end
    end

    always_comb begin
        state_d    = state_q;
        char_idx_d = char_idx_q;
        cond_idx_d = cond_idx_q;
        snap_en    = 1'b0;
        tx_valid   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    snap_en    = 1'b1;
                    char_idx_d = 4'd0;
                    cond_idx_d = 2'd0;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_valid = 1'b1;
                if (tx_ready) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (tx_done) begin
                    if (char_idx_q == LAST_CHAR) begin
                        char_idx_d = 4'd0;
                        if (cond_idx_q == LAST_COND) begin
                            cond_idx_d = 2'd0;
                            state_d    = ST_FINISH;
                        end else begin
                            cond_idx_d = cond_idx_q + 2'd1;
                            state_d    = ST_LOAD;
                        end
                    end else begin
                        char_idx_d = char_idx_q + 4'd1;
                        state_d    = ST_LOAD;
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Chars 3..10 walk the snapshot word from its most significant nibble down
    always_comb begin
        cur_word = snap_q[cond_idx_q];
        nib_k    = char_idx_q - 4'd3;
        cur_nib  = cur_word[5'd28 - {nib_k[2:0], 2'b00} +: 4];
        case (char_idx_q)
            4'd0:    tx_data = ASCII_C;
            4'd1:    tx_data = ASCII_0 + {6'd0, cond_idx_q};
            4'd2:    tx_data = ASCII_EQ;
            4'd11:   tx_data = ASCII_CR;
            4'd12:   tx_data = ASCII_LF;
            default: tx_data = hex_ascii(cur_nib);
        endcase
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .sysclk   (sysclk),
        .rst      (rst),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .tx_done  (tx_done),
        .uart_tx  (bus.uart_tx)
    );

    assign bus.busy = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
    assign bus.done = (state_q == ST_FINISH);

endmodule
`default_nettype wire
